// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a one-cycle registered output stage and character-cell coordinates.
// Optional colour-bar test pattern when VGA_TESTPAT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 8,
  parameter int AW       = 10,
  parameter int CELL_W   = 9,
  parameter int CELL_H   = 16,
  parameter int CCW      = 7,
  parameter int CRW      = 5
) (
  input  logic            pclk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [3*CW-1:0] vga_data,
  output logic [AW-1:0]   h_addr,
  output logic [AW-1:0]   v_addr,
  output logic            addr_valid,
  output logic [CCW-1:0]  char_col,
  output logic [CRW-1:0]  char_row,
  output logic [3:0]      cell_x,
  output logic [3:0]      cell_y,
  output logic            hsync,
  output logic            vsync,
  output logic            valid,
  output logic            frame_start,
  output logic            line_start,
  output logic [CW-1:0]   vga_r,
  output logic [CW-1:0]   vga_g,
  output logic [CW-1:0]   vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [AW-1:0] H_ACT  = AW'(H_ACTIVE);
  localparam logic [AW-1:0] H_SS   = AW'(H_ACTIVE + H_FP);
  localparam logic [AW-1:0] H_SE   = AW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [AW-1:0] H_LAST = AW'(H_TOTAL - 1);
  localparam logic [AW-1:0] V_ACT  = AW'(V_ACTIVE);
  localparam logic [AW-1:0] V_SS   = AW'(V_ACTIVE + V_FP);
  localparam logic [AW-1:0] V_SE   = AW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [AW-1:0] V_LAST = AW'(V_TOTAL - 1);
  localparam logic [3:0]    CX_LAST = 4'(CELL_W - 1);
  localparam logic [3:0]    CY_LAST = 4'(CELL_H - 1);
  localparam logic          HS_ON  = (HS_POL != 0);
  localparam logic          VS_ON  = (VS_POL != 0);

  logic [AW-1:0]   h_cnt_p0;
  logic [AW-1:0]   v_cnt_p0;
  logic [3:0]      cell_x_p0;
  logic [3:0]      cell_y_p0;
  logic [CCW-1:0]  char_col_p0;
  logic [CRW-1:0]  char_row_p0;

  logic            h_last;
  logic            v_last;
  logic            act_p0;
  logic            hs_act_p0;
  logic            vs_act_p0;
  logic [3*CW-1:0] src_colour_p0;

  logic            vld_p1;
  logic            hsync_p1;
  logic            vsync_p1;
  logic            frame_start_p1;
  logic            line_start_p1;
  logic [3*CW-1:0] colour_p1;

  // Blanking forces black; anything outside the visible window never reaches the DAC.
  function automatic logic [3*CW-1:0] blank_colour(input logic act, input logic [3*CW-1:0] c);
    return act ? c : '0;
  endfunction

  function automatic logic sync_level(input logic in_pulse, input logic on_level);
    return in_pulse ? on_level : ~on_level;
  endfunction

`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;

  // Bar index found by threshold compares; channel bits fall out of the index directly.
  function automatic logic [3*CW-1:0] bar_colour(input logic [AW-1:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= AW'(k * BAR_W)) idx = 3'(k);
    end
    return {{CW{~idx[1]}}, {CW{~idx[2]}}, {CW{~idx[0]}}};
  endfunction
`endif

  // ---- stage p0: scan counters and character-cell coordinates ----
  assign h_last = (h_cnt_p0 == H_LAST);
  assign v_last = (v_cnt_p0 == V_LAST);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (en) begin
      if (h_last) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= v_last ? '0 : v_cnt_p0 + 1'b1;
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cell_x_p0   <= '0;
      char_col_p0 <= '0;
    end else if (en) begin
      if (h_last) begin
        cell_x_p0   <= '0;
        char_col_p0 <= '0;
      end else if (cell_x_p0 == CX_LAST) begin
        cell_x_p0   <= '0;
        char_col_p0 <= char_col_p0 + 1'b1;
      end else begin
        cell_x_p0   <= cell_x_p0 + 1'b1;
      end
    end
  end

  // Row coordinates advance only on the line wrap, mirroring the column scheme.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cell_y_p0   <= '0;
      char_row_p0 <= '0;
    end else if (en && h_last) begin
      if (v_last) begin
        cell_y_p0   <= '0;
        char_row_p0 <= '0;
      end else if (cell_y_p0 == CY_LAST) begin
        cell_y_p0   <= '0;
        char_row_p0 <= char_row_p0 + 1'b1;
      end else begin
        cell_y_p0   <= cell_y_p0 + 1'b1;
      end
    end
  end

  assign act_p0    = (h_cnt_p0 < H_ACT) && (v_cnt_p0 < V_ACT);
  assign hs_act_p0 = (h_cnt_p0 >= H_SS) && (h_cnt_p0 <= H_SE);
  assign vs_act_p0 = (v_cnt_p0 >= V_SS) && (v_cnt_p0 <= V_SE);

  assign addr_valid = act_p0;
  assign h_addr     = act_p0 ? h_cnt_p0 : '0;
  assign v_addr     = act_p0 ? v_cnt_p0 : '0;
  assign char_col   = char_col_p0;
  assign char_row   = char_row_p0;
  assign cell_x     = cell_x_p0;
  assign cell_y     = cell_y_p0;

`ifdef VGA_TESTPAT_EN
  assign src_colour_p0 = bar_colour(h_addr);
`else
  assign src_colour_p0 = vga_data;
`endif

  // ---- stage p1: registered DAC-facing outputs ----
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1         <= 1'b0;
      colour_p1      <= '0;
      frame_start_p1 <= 1'b0;
      line_start_p1  <= 1'b0;
      hsync_p1       <= ~HS_ON;
      vsync_p1       <= ~VS_ON;
    end else if (en) begin
      vld_p1         <= act_p0;
      colour_p1      <= blank_colour(act_p0, src_colour_p0);
      frame_start_p1 <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      line_start_p1  <= (h_cnt_p0 == '0) && (v_cnt_p0 < V_ACT);
      hsync_p1       <= sync_level(hs_act_p0, HS_ON);
      vsync_p1       <= sync_level(vs_act_p0, VS_ON);
    end else begin
      // Stalled: blank and suppress pulses, but keep sync levels steady.
      vld_p1         <= 1'b0;
      colour_p1      <= '0;
      frame_start_p1 <= 1'b0;
      line_start_p1  <= 1'b0;
    end
  end

  assign valid       = vld_p1;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign frame_start = frame_start_p1;
  assign line_start  = line_start_p1;
  assign vga_r       = colour_p1[3*CW-1:2*CW];
  assign vga_g       = colour_p1[2*CW-1:CW];
  assign vga_b       = colour_p1[CW-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a reduced raster, checked against a position-based reference model.
module tb_vga_timing_gen;

  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int HSP = 0, VSP = 1;
  localparam int CW = 8, AW = 10, CWD = 9, CHT = 16, CCW = 7, CRW = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic            pclk;
  logic            reset_n;
  logic            en;
  logic [3*CW-1:0] vga_data;
  logic [AW-1:0]   h_addr, v_addr;
  logic            addr_valid;
  logic [CCW-1:0]  char_col;
  logic [CRW-1:0]  char_row;
  logic [3:0]      cell_x, cell_y;
  logic            hsync, vsync, valid, frame_start, line_start;
  logic [CW-1:0]   vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CW(CW), .AW(AW),
    .CELL_W(CWD), .CELL_H(CHT), .CCW(CCW), .CRW(CRW)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .en(en), .vga_data(vga_data),
    .h_addr(h_addr), .v_addr(v_addr), .addr_valid(addr_valid),
    .char_col(char_col), .char_row(char_row), .cell_x(cell_x), .cell_y(cell_y),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .frame_start(frame_start), .line_start(line_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;

  // Reference: scan position plus the registered outputs expected after the next edge.
  int          mx, my;
  logic        e_vld, e_fs, e_ls, e_hs, e_vs;
  logic [23:0] e_col;

  int fs_first, fs_second, ls_n, vs_n, hs_n, vld_n;
  logic [23:0] sd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (x=%0d y=%0d t=%0t)", tag, got, exp, mx, my, $time);
    end
  endtask

  function automatic logic [23:0] colour_ref(input int x, input logic [23:0] d);
`ifdef VGA_TESTPAT_EN
    case (x / (HA / 8))
      0: return 24'hffffff;
      1: return 24'hffff00;
      2: return 24'h00ffff;
      3: return 24'h00ff00;
      4: return 24'hff00ff;
      5: return 24'hff0000;
      6: return 24'h0000ff;
      default: return 24'h000000;
    endcase
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    mx = 0; my = 0;
    e_vld = 0; e_col = '0; e_fs = 0; e_ls = 0;
    e_hs = (HSP == 0); e_vs = (VSP == 0);
  endtask

  task automatic check_comb();
    logic act;
    act = (mx < HA) && (my < VA);
    check("addr_valid", addr_valid, act);
    check("h_addr", h_addr, act ? mx : 0);
    check("v_addr", v_addr, act ? my : 0);
    check("char_col", char_col, (mx / CWD) % (1 << CCW));
    check("cell_x", cell_x, mx % CWD);
    check("char_row", char_row, (my / CHT) % (1 << CRW));
    check("cell_y", cell_y, my % CHT);
  endtask

  // One pixel clock: drive at a falling edge, predict, then check after the next falling edge.
  task automatic step(input logic e, input logic [23:0] d);
    logic act;
    en = e;
    vga_data = d;
    if (e) begin
      act   = (mx < HA) && (my < VA);
      e_vld = act;
      e_col = act ? colour_ref(mx, d) : 24'h0;
      e_fs  = (mx == 0) && (my == 0);
      e_ls  = (mx == 0) && (my < VA);
      e_hs  = (mx >= HA + HF && mx < HA + HF + HS) ? (HSP != 0) : (HSP == 0);
      e_vs  = (my >= VA + VF && my < VA + VF + VS) ? (VSP != 0) : (VSP == 0);
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
    end else begin
      e_vld = 0; e_col = '0; e_fs = 0; e_ls = 0;
    end
    @(negedge pclk);
    check("valid", valid, e_vld);
    check("colour", {vga_r, vga_g, vga_b}, e_col);
    check("frame_start", frame_start, e_fs);
    check("line_start", line_start, e_ls);
    check("hsync", hsync, e_hs);
    check("vsync", vsync, e_vs);
    check_comb();
  endtask

  task automatic seek(input int x, input int y, input logic [23:0] d, input string tag);
    for (int i = 0; i < HT * VT + 1 && !(mx == x && my == y); i++) step(1'b1, d);
    check(tag, (mx == x) && (my == y), 1);
  endtask

  task automatic async_reset(input string tag);
    #3 reset_n = 1'b0;
    #1;
    check({tag, "_valid"}, valid, 0);
    check({tag, "_colour"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_ls"}, line_start, 0);
    check({tag, "_hsync"}, hsync, (HSP == 0));
    check({tag, "_vsync"}, vsync, (VSP == 0));
    check({tag, "_h_addr"}, h_addr, 0);
    check({tag, "_cell_x"}, cell_x, 0);
    check({tag, "_char_col"}, char_col, 0);
    check({tag, "_cell_y"}, cell_y, 0);
    @(negedge pclk);
    @(negedge pclk);
    reset_n = 1'b1;
    model_reset();
    step(1'b1, $urandom);
    check({tag, "_post_fs"}, frame_start, 1);
    check({tag, "_post_valid"}, valid, 1);
  endtask

  initial begin
    pclk = 1'b0; reset_n = 1'b0; en = 1'b0; vga_data = '0;
    model_reset();
    repeat (3) @(negedge pclk);
    check("rst_valid", valid, 0);
    check("rst_colour", {vga_r, vga_g, vga_b}, 0);
    check("rst_fs", frame_start, 0);
    check("rst_ls", line_start, 0);
    check("rst_hsync", hsync, (HSP == 0));
    check("rst_vsync", vsync, (VSP == 0));

    reset_n = 1'b1;
    check_comb();

    // One full frame with en held high: pulse spacing and sync widths.
    fs_first = -1; fs_second = -1; ls_n = 0; vs_n = 0; hs_n = 0; vld_n = 0;
    for (int i = 1; i <= HT * VT + 1; i++) begin
      step(1'b1, $urandom);
      if (frame_start) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (i <= HT * VT) begin
        ls_n  += int'(line_start);
        vs_n  += int'(vsync == 1'(VSP));
        vld_n += int'(valid);
        if (i <= HT) hs_n += int'(hsync == 1'(HSP));
      end
    end
    check("fs_first", fs_first, 1);
    check("fs_period", fs_second - fs_first, HT * VT);
    check("ls_count", ls_n, VA);
    check("vs_cycles", vs_n, VS * HT);
    check("hs_cycles", hs_n, HS);
    check("vld_count", vld_n, HA * VA);

    // Random enable stalls and colour data.
    for (int i = 0; i < 3000; i++) step(($urandom_range(0, 9) != 0), $urandom);

    // Directed stall in the middle of an active line.
    seek(10, 1, $urandom, "stall_seek");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, $urandom);
      check("stall_h_addr", h_addr, 10);
      check("stall_valid", valid, 0);
    end
    sd = $urandom;
    step(1'b1, sd);
    check("resume_colour", {vga_r, vga_g, vga_b}, colour_ref(10, sd));
    check("resume_h_addr", h_addr, 11);

    // Asynchronous reset inside the active area and inside both sync pulses.
    seek(21, 5, 24'ha5a5a5, "seek_active");
    check("pre_rst_valid", valid, 1);
    async_reset("arst_active");
    seek(HA + HF + 2, VA + VF, $urandom, "seek_sync");
    check("pre_rst_hsync", hsync, 1'(HSP));
    async_reset("arst_sync");

    for (int i = 0; i < 200; i++) step(($urandom_range(0, 3) != 0), $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing and pixel-pipeline generator; successor to the fixed 640x480 controller.
- Produces a scan address and character-cell coordinates for the upstream text/graphics source, and samples that source's colour.
- Drives registered, mutually aligned sync/blank/colour outputs to the DAC pins.
- Timing, sync polarity, colour depth and character cell size are all parameters; adds an enable stall and frame/line start pulses.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level
- VS_POL, 0, vsync asserted level
- CW, 8, bits per colour channel
- AW, 10, width of h_addr, v_addr and internal counters
- CELL_W, 9, character cell width (pixels)
- CELL_H, 16, character cell height (lines)
- CCW, 7, char_col width
- CRW, 5, char_row width

Ports:
- pclk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  timing advance enable
- vga_data  in  3*CW  colour for current h_addr/v_addr, {r,g,b}
- h_addr  out  AW  current visible column (0 when not addr_valid)
- v_addr  out  AW  current visible line (0 when not addr_valid)
- addr_valid  out  1  counters inside active area
- char_col  out  CCW  character column of h_addr
- char_row  out  CRW  character row of v_addr
- cell_x  out  4  column inside cell, 0..CELL_W-1
- cell_y  out  4  line inside cell, 0..CELL_H-1
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- valid  out  1  registered display-enable
- frame_start  out  1  one-cycle pulse with first output pixel of frame
- line_start  out  1  one-cycle pulse with first output pixel of each active line
- vga_r, vga_g, vga_b  out  CW each  registered colour

Behaviour:

Counters
- h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
- Line order is active, front porch, sync, back porch.
- h_cnt wraps to 0 at H_TOTAL-1. v_cnt increments only on that wrap, and wraps to 0 at V_TOTAL-1 coinciding with the h wrap.

Address stage (combinational from counters)
- addr_valid = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- h_addr = h_cnt and v_addr = v_cnt when addr_valid, else 0.

Character coordinates (no dividers)
- cell_x/char_col are registered counters stepped alongside h_cnt.
  - cell_x wraps at CELL_W-1 and increments char_col.
  - Both clear when h_cnt wraps to 0.
- cell_y/char_row step once per line using the same scheme at CELL_H, and clear when v_cnt wraps.
- A partial last cell is allowed: at default parameters, h_addr 639 gives char_col 71, cell_x 0.

Output stage (1-cycle latency, all registered)
- hsync = HS_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else !HS_POL. vsync is defined the same way on v_cnt.
- valid <= addr_valid.
- Colour: {vga_r,vga_g,vga_b} <= addr_valid ? vga_data : 0.
- frame_start <= (h_cnt==0 & v_cnt==0).
- line_start <= (h_cnt==0 & v_cnt<V_ACTIVE).
- The upstream source therefore has exactly one pclk to return vga_data for the presented h_addr/v_addr.

Enable
- en=0: all counters hold their values.
- Registered outputs during the stall: valid=0, colour=0, pulses=0, hsync/vsync hold their last level.
- en returning to 1 resumes from the held position with no skipped pixel.

Reset
- reset_n low, at any time including mid-frame, clears counters and character coordinates to 0.
- Output reset values: valid=0, colour=0, frame_start=0, line_start=0, hsync=!HS_POL, vsync=!VS_POL.
- The first cycle after release presents pixel (0,0); frame_start rises on the following cycle.

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- Defined: 8 vertical colour bars of width H_ACTIVE/8, selected from h_addr, replace vga_data in the output stage. Bar order: white, yellow, cyan, green, magenta, red, blue, black; each channel is all-ones or 0. Sync and blank timing are unchanged.
- Undefined: colour comes from vga_data only, and the pattern logic is absent.

Test Plan:
- Release reset_n, en=1, defaults → frame_start high exactly 1 cycle later with valid=1; next frame_start 420000 cycles after it.
- Within line 0 → valid high for output cycles 1..640, hsync low for cycles 657..752, line period 800 cycles.
- Across frame → vsync low for exactly 2 lines starting at v_cnt 490; line_start pulses 480 times per frame.
- Char coords → h_addr 8 gives char_col 0, cell_x 8; h_addr 9 gives char_col 1, cell_x 0; v_addr 16 gives char_row 1, cell_y 0; v_addr 479 gives char_row 29, cell_y 15.
- en low 5 cycles at h_addr 100 → h_addr stays 100, valid/colour 0; after re-enable the next output pixel equals vga_data sampled at h_addr 100. Assert reset_n mid-frame → outputs at reset values immediately (asynchronously).
- VGA_TESTPAT_EN defined, vga_data=0 → pixel h_addr 0 gives ffffff, 80 gives ffff00, 560 gives 000000.
